// File: rtl/rq_arb_pkg.sv
// Shared types and helpers for the request queue arbiter.
// Credit is sized for the default queue depth; the top sizes its counter from LSIZE.
package rq_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      WAIT_INIT,
      RUN,
      ERROR
   } ArbState;

   // Three bits cover the full 2..8 requester range.
   localparam int REQ_ID_W = 3;
   typedef logic [REQ_ID_W-1:0] ReqId;

   localparam int CREDIT_LSIZE = 3;
   typedef logic [CREDIT_LSIZE:0] Credit;

   // Position of the requester 'offset' places after 'base', wrapping at num_req.
   function automatic int rr_pos(input ReqId base, input int offset, input int num_req);
      int p;
      p = int'(base) + offset;
      if (p >= num_req) p = p - num_req;
      return p;
   endfunction

   function automatic ReqId rr_next(input ReqId id, input int num_req);
      if (int'(id) + 1 >= num_req) return '0;
      return id + ReqId'(1);
   endfunction

endpackage

// File: rtl/rq_arb_tag_fifo.sv
// FIFO of requester ids for pushes in flight to the queue, depth 2**LDEPTH.
// Pushes while full and pops while empty are dropped.
module rq_arb_tag_fifo
   import rq_arb_pkg::*;
#(
   parameter int LDEPTH = 2
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                push_in,
   input  logic [REQ_ID_W-1:0] push_id_in,
   input  logic                pop_in,
   output logic [REQ_ID_W-1:0] pop_id_out,
   output logic                full_out,
   output logic                empty_out
);

   localparam int DEPTH = 2 ** LDEPTH;
   localparam logic [LDEPTH:0] PTR_ONE = {{LDEPTH{1'b0}}, 1'b1};

   ReqId            mem_q [DEPTH];
   logic [LDEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LDEPTH:0] rd_ptr_q, rd_ptr_d;
   logic            do_push, do_pop;

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign full_out  = (wr_ptr_q[LDEPTH] != rd_ptr_q[LDEPTH]) &&
                      (wr_ptr_q[LDEPTH-1:0] == rd_ptr_q[LDEPTH-1:0]);
   assign empty_out = (wr_ptr_q == rd_ptr_q);
   assign do_push   = push_in && !full_out;
   assign do_pop    = pop_in && !empty_out;
   assign wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d  = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   assign pop_id_out = mem_q[rd_ptr_q[LDEPTH-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[LDEPTH-1:0]] <= push_id_in;
   end

endmodule

// File: rtl/request_queue_arbiter.sv
// Round-robin push arbiter with credit tracking in front of a shared request_queue.
// Define REQUEST_QUEUE_ARB_STATS_EN to add per-requester accept counters.
module request_queue_arbiter
   import rq_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LSIZE      = 3,
   parameter int TAG_LDEPTH = 2
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   output logic [NUM_REQ-1:0]            done_valid_out,
   output logic [LSIZE-1:0]              done_slot_id_out,
   output logic                          rq_initialize_out,
   input  logic                          rq_initialized_in,
   output logic                          rq_push_en_out,
   output logic [DATA_WIDTH-1:0]         rq_push_data_out,
   input  logic                          rq_push_done_in,
   input  logic [LSIZE-1:0]              rq_push_slot_id_in,
   input  logic                          rq_pop_en_in,
   output logic [LSIZE:0]                credits_out,
   output logic                          ready_out,
   output logic                          error_out
`ifdef REQUEST_QUEUE_ARB_STATS_EN
   ,
   input  logic [$clog2(NUM_REQ)-1:0]    stats_sel_in,
   output logic [31:0]                   stats_cnt_out
`endif
);

   localparam logic [LSIZE:0] CREDIT_MAX = {1'b1, {LSIZE{1'b0}}};
   localparam logic [LSIZE:0] CREDIT_ONE = {{LSIZE{1'b0}}, 1'b1};

   ArbState                 state_q, state_d;
   logic [LSIZE:0]          credits_q, credits_d;
   ReqId                    ptr_q, ptr_d;
   logic                    push_en_q;
   logic [DATA_WIDTH-1:0]   push_data_q;
   logic [NUM_REQ-1:0]      done_vld_q;
   logic [LSIZE-1:0]        done_slot_q;

   logic                    gnt_found;
   ReqId                    gnt_id;
   logic [NUM_REQ-1:0]      gnt_oh;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic                    grant_en;
   logic                    accept;
   logic                    pop_ok;
   logic                    run_err;
   logic                    done_fire;
   logic [NUM_REQ-1:0]      done_oh;

   ReqId                    tag_rd;
   logic                    tag_full, tag_empty;

   rq_arb_tag_fifo #(
      .LDEPTH (TAG_LDEPTH)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_in    (accept),
      .push_id_in (gnt_id),
      .pop_in     (rq_push_done_in),
      .pop_id_out (tag_rd),
      .full_out   (tag_full),
      .empty_out  (tag_empty)
   );

   // First valid requester at or after the pointer, scanning upward with wrap.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_oh    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid_in[i] && (rr_pos(ptr_q, k, NUM_REQ) == i)) begin
               gnt_found = 1'b1;
               gnt_id    = ReqId'(i);
               gnt_oh[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      done_oh  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_oh[i]) gnt_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
         done_oh[i] = (tag_rd == ReqId'(i));
      end
   end

   assign grant_en  = (state_q == RUN) && (credits_q != '0) && !tag_full;
   assign accept    = grant_en && gnt_found;
   assign pop_ok    = rq_pop_en_in && (credits_q != CREDIT_MAX);
   assign done_fire = rq_push_done_in && !tag_empty;
   // Protocol violations are only judged once credits are live in RUN.
   assign run_err   = (rq_push_done_in && tag_empty) ||
                      (rq_pop_en_in && (credits_q == CREDIT_MAX));

   always_comb begin
      state_d           = state_q;
      credits_d         = credits_q;
      ptr_d             = ptr_q;
      rq_initialize_out = 1'b0;
      ready_out         = 1'b0;
      error_out         = 1'b0;
      req_ready_out     = grant_en ? gnt_oh : '0;
      case (state_q)
         IDLE: begin
            if (start_in) state_d = INIT;
         end
         INIT: begin
            rq_initialize_out = 1'b1;
            state_d           = WAIT_INIT;
         end
         WAIT_INIT: begin
            if (rq_initialized_in) begin
               state_d   = RUN;
               credits_d = CREDIT_MAX;
            end
         end
         RUN: begin
            ready_out = 1'b1;
            if (run_err) state_d = ERROR;
            if (accept && !pop_ok) credits_d = credits_q - CREDIT_ONE;
            else if (!accept && pop_ok) credits_d = credits_q + CREDIT_ONE;
         end
         ERROR: begin
            error_out = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (accept) ptr_d = rr_next(gnt_id, NUM_REQ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         credits_q   <= '0;
         ptr_q       <= '0;
         push_en_q   <= 1'b0;
         push_data_q <= '0;
         done_vld_q  <= '0;
         done_slot_q <= '0;
      end else begin
         state_q   <= state_d;
         credits_q <= credits_d;
         ptr_q     <= ptr_d;
         push_en_q <= accept;
         if (accept) push_data_q <= gnt_data;
         done_vld_q <= done_fire ? done_oh : '0;
         if (done_fire) done_slot_q <= rq_push_slot_id_in;
      end
   end

   assign rq_push_en_out   = push_en_q;
   assign rq_push_data_out = push_data_q;
   assign done_valid_out   = done_vld_q;
   assign done_slot_id_out = done_slot_q;
   assign credits_out      = credits_q;

`ifdef REQUEST_QUEUE_ARB_STATS_EN
   localparam int SEL_W = $clog2(NUM_REQ);

   logic [31:0] acc_cnt_q [NUM_REQ];
   logic [31:0] stats_cnt_q, stats_cnt_d;

   always_comb begin
      stats_cnt_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stats_sel_in == SEL_W'(i)) stats_cnt_d = acc_cnt_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) acc_cnt_q[i] <= '0;
         stats_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && gnt_oh[i]) acc_cnt_q[i] <= acc_cnt_q[i] + 32'd1;
         end
         stats_cnt_q <= stats_cnt_d;
      end
   end

   assign stats_cnt_out = stats_cnt_q;
`else
   // Accept counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_request_queue_arbiter.sv
// Scoreboard bench for request_queue_arbiter: directed vectors, a queue-side
// responder, and a monitor that checks every push and done the DUT emits.
module tb_request_queue_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int LSIZE      = 3;

   logic                          clk = 1'b0;
   logic                          reset = 1'b0;
   logic                          start_in = 1'b0;
   logic [NUM_REQ-1:0]            req_valid_in = '0;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in = '0;
   logic [NUM_REQ-1:0]            req_ready_out;
   logic [NUM_REQ-1:0]            done_valid_out;
   logic [LSIZE-1:0]              done_slot_id_out;
   logic                          rq_initialize_out;
   logic                          rq_initialized_in = 1'b0;
   logic                          rq_push_en_out;
   logic [DATA_WIDTH-1:0]         rq_push_data_out;
   logic                          rq_push_done_in;
   logic [LSIZE-1:0]              rq_push_slot_id_in;
   logic                          rq_pop_en_in = 1'b0;
   logic [LSIZE:0]                credits_out;
   logic                          ready_out;
   logic                          error_out;

   logic       force_done = 1'b0;
   logic [2:0] force_slot = '0;
   logic       emu_done = 1'b0;
   logic [2:0] emu_slot = '0;
   logic [2:0] slot_ctr = '0;
   bit         auto_en = 1'b1;

   assign rq_push_done_in    = force_done | emu_done;
   assign rq_push_slot_id_in = force_done ? force_slot : emu_slot;

   int n_tests = 0;
   int n_fail = 0;
   int init_pulses = 0;

   logic [7:0] exp_push [$];
   int         exp_tag [$];
   logic [6:0] exp_done [$];

   logic       emu_pe;
   int         emu_g;
   logic [3:0] emu_oh;
   logic [6:0] mon_e;

   request_queue_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .LSIZE      (LSIZE),
      .TAG_LDEPTH (2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start_in           (start_in),
      .req_valid_in       (req_valid_in),
      .req_data_in        (req_data_in),
      .req_ready_out      (req_ready_out),
      .done_valid_out     (done_valid_out),
      .done_slot_id_out   (done_slot_id_out),
      .rq_initialize_out  (rq_initialize_out),
      .rq_initialized_in  (rq_initialized_in),
      .rq_push_en_out     (rq_push_en_out),
      .rq_push_data_out   (rq_push_data_out),
      .rq_push_done_in    (rq_push_done_in),
      .rq_push_slot_id_in (rq_push_slot_id_in),
      .rq_pop_en_in       (rq_pop_en_in),
      .credits_out        (credits_out),
      .ready_out          (ready_out),
      .error_out          (error_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic expect_grant(input int g, input logic [7:0] d);
      chk($sformatf("grant_%0d", g), 32'(req_ready_out), 32'(1 << g));
      exp_push.push_back(d);
      if (auto_en) exp_tag.push_back(g);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready_out), 0);
      chk({tag, "_done_valid"}, 32'(done_valid_out), 0);
      chk({tag, "_initialize"}, 32'(rq_initialize_out), 0);
      chk({tag, "_push_en"}, 32'(rq_push_en_out), 0);
      chk({tag, "_push_data"}, 32'(rq_push_data_out), 0);
      chk({tag, "_credits"}, 32'(credits_out), 0);
      chk({tag, "_ready"}, 32'(ready_out), 0);
      chk({tag, "_error"}, 32'(error_out), 0);
   endtask

   initial forever begin
      @(negedge clk);
      if (rq_initialize_out) init_pulses++;
   end

   // Queue responder: completes each push one cycle after its strobe.
   initial forever begin
      @(negedge clk);
      emu_pe = rq_push_en_out;
      @(posedge clk);
      #1;
      emu_done = 1'b0;
      if (emu_pe && auto_en && exp_tag.size() > 0) begin
         emu_g    = exp_tag.pop_front();
         emu_oh   = 4'(1 << emu_g);
         emu_done = 1'b1;
         emu_slot = slot_ctr;
         exp_done.push_back({emu_oh, slot_ctr});
         slot_ctr = slot_ctr + 3'd1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rq_push_en_out) begin
         if (exp_push.size() == 0) chk("unexpected_push", 32'(rq_push_en_out), 0);
         else chk("push_data", 32'(rq_push_data_out), 32'(exp_push.pop_front()));
      end
      if (done_valid_out != '0) begin
         if (exp_done.size() == 0) chk("unexpected_done", 32'(done_valid_out), 0);
         else begin
            mon_e = exp_done.pop_front();
            chk("done_valid", 32'(done_valid_out), 32'(mon_e[6:3]));
            chk("done_slot", 32'(done_slot_id_out), 32'(mon_e[2:0]));
         end
      end
   end

   initial begin
      req_data_in = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (2) cyc();
      mid();
      check_idle("rst");
      cyc();
      reset = 1'b1;

      // Initialization handshake
      cyc(); start_in = 1'b1;
      cyc(); start_in = 1'b0;
      mid();
      chk("t1_init_pulse", 32'(rq_initialize_out), 1);
      cyc(); mid();
      chk("t1_wait_ready", 32'(ready_out), 0);
      chk("t1_wait_pulse", 32'(rq_initialize_out), 0);
      cyc(); cyc(); rq_initialized_in = 1'b1;
      cyc(); mid();
      chk("t1_ready", 32'(ready_out), 1);
      chk("t1_credits", 32'(credits_out), 8);
      chk("t1_pulses", 32'(init_pulses), 1);

      // Round robin across all requesters until credits run out
      cyc(); req_valid_in = 4'hF;
      for (int k = 0; k < 8; k++) begin
         mid();
         chk($sformatf("t2_credits_%0d", k), 32'(credits_out), 32'(8 - k));
         expect_grant(k % 4, 8'h10 + 8'(k % 4));
         cyc();
      end
      mid();
      chk("t2_credits0", 32'(credits_out), 0);
      chk("t2_no_grant", 32'(req_ready_out), 0);
      cyc(); mid();
      chk("t2_no_grant2", 32'(req_ready_out), 0);

      // One pop at zero credits releases exactly one grant, next cycle
      cyc(); rq_pop_en_in = 1'b1;
      mid();
      chk("t3_pop_cycle", 32'(req_ready_out), 0);
      cyc(); rq_pop_en_in = 1'b0;
      mid();
      expect_grant(0, 8'h10);
      cyc(); mid();
      chk("t3_after", 32'(req_ready_out), 0);
      chk("t3_credits", 32'(credits_out), 0);

      // Accept and pop together leave credits unchanged
      cyc(); req_valid_in = '0; rq_pop_en_in = 1'b1;
      cyc(); cyc(); cyc(); rq_pop_en_in = 1'b0;
      mid();
      chk("t5_credits3", 32'(credits_out), 3);
      cyc(); req_valid_in = 4'b0010; rq_pop_en_in = 1'b1;
      mid();
      expect_grant(1, 8'h11);
      cyc(); req_valid_in = '0; rq_pop_en_in = 1'b0;
      mid();
      chk("t5_credits_net", 32'(credits_out), 3);

      // Slot id routed back to requester 2
      repeat (4) cyc();
      auto_en = 1'b0;
      req_data_in[23:16] = 8'h5A;
      req_valid_in = 4'b0100;
      mid();
      expect_grant(2, 8'h5A);
      cyc(); req_valid_in = '0;
      cyc(); force_done = 1'b1; force_slot = 3'd5;
      exp_done.push_back({4'b0100, 3'd5});
      cyc(); force_done = 1'b0;
      mid();
      chk("t4_done_valid", 32'(done_valid_out), 32'h4);
      chk("t4_done_slot", 32'(done_slot_id_out), 5);
      chk("t4_credits", 32'(credits_out), 2);

      // Completion with nothing in flight is fatal until reset
      cyc(); force_done = 1'b1; force_slot = 3'd0;
      cyc(); force_done = 1'b0;
      mid();
      chk("t6_error", 32'(error_out), 1);
      chk("t6_ready", 32'(ready_out), 0);
      cyc(); req_valid_in = 4'hF;
      mid();
      chk("t6_no_grant", 32'(req_ready_out), 0);
      cyc(); mid();
      chk("t6_no_grant2", 32'(req_ready_out), 0);
      reset = 1'b0;
      #1;
      check_idle("t6_async");
      cyc(); req_valid_in = '0;
      mid();
      check_idle("t6_reset");

      // Reset asserted mid-INIT
      cyc(); reset = 1'b1;
      cyc(); start_in = 1'b1;
      cyc(); start_in = 1'b0;
      mid();
      chk("mi_init", 32'(rq_initialize_out), 1);
      reset = 1'b0;
      #1;
      check_idle("mi");
      cyc(); reset = 1'b1;

      // Pop with the queue already empty of entries
      cyc(); start_in = 1'b1;
      cyc(); start_in = 1'b0;
      cyc(); cyc(); mid();
      chk("pf_ready", 32'(ready_out), 1);
      chk("pf_credits8", 32'(credits_out), 8);
      cyc(); rq_pop_en_in = 1'b1;
      cyc(); rq_pop_en_in = 1'b0;
      mid();
      chk("pf_error", 32'(error_out), 1);
      chk("pf_credits", 32'(credits_out), 8);
      chk("pf_not_ready", 32'(ready_out), 0);

      repeat (2) cyc();
      chk("sb_push_drained", 32'(exp_push.size()), 0);
      chk("sb_done_drained", 32'(exp_done.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
